// File: rtl/ifu_fetch.sv
// Instruction fetch unit: keeps at most one memory request in flight, holds the
// fetched word for the decoder, and applies EXU redirects ahead of all other events.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_ifu_req_valid,
  input  logic        i_mem_req_ready,
  output logic [31:0] o_ifu_req_addr,
  input  logic        i_mem_rsp_valid,
  input  logic [31:0] i_mem_rsp_data,
  output logic        o_ifu_valid,
  input  logic        i_idu_ready,
  output logic [31:0] o_ifu_pc,
  output logic [31:0] o_ifu_inst,
  input  logic        i_exu_redirect,
  input  logic [31:0] i_exu_redirect_pc,
  output logic [31:0] o_ifu_fetch_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_DROP = 3'd3,
    S_HOLD = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifu_pc_q, ifu_pc_d;
  logic [31:0] ifu_inst_q, ifu_inst_d;
  logic [31:0] cnt_q, cnt_d;

  logic        fire;
  logic [31:0] redir_tgt;

  assign fire      = (state_q == S_REQ) && i_mem_req_ready;
  assign redir_tgt = i_exu_redirect_pc & ~32'h3;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ifu_pc_d   = ifu_pc_q;
    ifu_inst_d = ifu_inst_q;
    cnt_d      = cnt_q;
    if (i_exu_redirect) pc_d = redir_tgt;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (fire) state_d = i_exu_redirect ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (i_exu_redirect) begin
          // a response landing with the redirect is for the old path; drop it now
          state_d = i_mem_rsp_valid ? S_REQ : S_DROP;
        end else if (i_mem_rsp_valid) begin
          ifu_inst_d = i_mem_rsp_data;
          ifu_pc_d   = pc_q;
          state_d    = S_HOLD;
        end
      end
      S_DROP: begin
        if (i_mem_rsp_valid) state_d = S_REQ;
      end
      S_HOLD: begin
        if (i_exu_redirect) begin
          state_d = S_REQ;
        end else if (i_idu_ready) begin
          pc_d    = pc_q + 32'd4;
          cnt_d   = cnt_q + 32'd1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      ifu_pc_q   <= RESET_PC;
      ifu_inst_q <= NOP_INST;
      cnt_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ifu_pc_q   <= ifu_pc_d;
      ifu_inst_q <= ifu_inst_d;
      cnt_q      <= cnt_d;
    end
  end

  // Outputs depend on registered state only.
  assign o_ifu_req_valid = (state_q == S_REQ);
  assign o_ifu_req_addr  = pc_q;
  assign o_ifu_valid     = (state_q == S_HOLD);
  assign o_ifu_pc        = ifu_pc_q;
  assign o_ifu_inst      = (state_q == S_HOLD) ? ifu_inst_q : NOP_INST;
  assign o_ifu_fetch_cnt = cnt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: reset, fetch/handoff sequencing, stalls, redirects.
module tb_ifu_fetch;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        o_ifu_req_valid;
  logic        i_mem_req_ready = 1'b0;
  logic [31:0] o_ifu_req_addr;
  logic        i_mem_rsp_valid = 1'b0;
  logic [31:0] i_mem_rsp_data = 32'h0;
  logic        o_ifu_valid;
  logic        i_idu_ready = 1'b0;
  logic [31:0] o_ifu_pc;
  logic [31:0] o_ifu_inst;
  logic        i_exu_redirect = 1'b0;
  logic [31:0] i_exu_redirect_pc = 32'h0;
  logic [31:0] o_ifu_fetch_cnt;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  ifu_fetch dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .o_ifu_req_valid(o_ifu_req_valid), .i_mem_req_ready(i_mem_req_ready),
    .o_ifu_req_addr(o_ifu_req_addr), .i_mem_rsp_valid(i_mem_rsp_valid),
    .i_mem_rsp_data(i_mem_rsp_data), .o_ifu_valid(o_ifu_valid),
    .i_idu_ready(i_idu_ready), .o_ifu_pc(o_ifu_pc), .o_ifu_inst(o_ifu_inst),
    .i_exu_redirect(i_exu_redirect), .i_exu_redirect_pc(i_exu_redirect_pc),
    .o_ifu_fetch_cnt(o_ifu_fetch_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // From REQ: fire with zero-wait memory, leaving the DUT in HOLD.
  task automatic fetch_one(input logic [31:0] data);
    i_mem_req_ready = 1'b1;
    step();
    i_mem_req_ready = 1'b0;
    i_mem_rsp_valid = 1'b1;
    i_mem_rsp_data  = data;
    step();
    i_mem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    step(); step();
    checks++; if (o_ifu_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid got=%0b exp=0", o_ifu_req_valid); end
    checks++; if (o_ifu_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", o_ifu_valid); end
    checks++; if (o_ifu_pc !== 32'h8000_0000) begin failures++; $display("FAIL rst_pc got=%h exp=80000000", o_ifu_pc); end
    checks++; if (o_ifu_inst !== NOP) begin failures++; $display("FAIL rst_inst got=%h exp=%h", o_ifu_inst, NOP); end
    checks++; if (o_ifu_fetch_cnt !== 32'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", o_ifu_fetch_cnt); end
    i_rst = 1'b1;
    step();
    checks++; if (o_ifu_req_valid !== 1'b1 || o_ifu_req_addr !== 32'h8000_0000) begin failures++;
      $display("FAIL first_req got=%0b/%h exp=1/80000000", o_ifu_req_valid, o_ifu_req_addr); end
  endtask

  task automatic test_first_fetch();
    i_mem_req_ready = 1'b1;
    step();
    i_mem_req_ready = 1'b0;
    checks++; if (o_ifu_req_valid !== 1'b0 || o_ifu_valid !== 1'b0) begin failures++;
      $display("FAIL wait_state got=%0b/%0b exp=0/0", o_ifu_req_valid, o_ifu_valid); end
    i_mem_rsp_valid = 1'b1; i_mem_rsp_data = 32'h0050_0093;
    step();
    i_mem_rsp_valid = 1'b0;
    checks++; if (o_ifu_valid !== 1'b1 || o_ifu_pc !== 32'h8000_0000 || o_ifu_inst !== 32'h0050_0093) begin failures++;
      $display("FAIL first_hold got=%0b/%h/%h exp=1/80000000/00500093", o_ifu_valid, o_ifu_pc, o_ifu_inst); end
  endtask

  task automatic test_back_to_back();
    i_idu_ready = 1'b1;
    step();
    checks++; if (o_ifu_fetch_cnt !== 32'd1 || o_ifu_req_addr !== 32'h8000_0004 || o_ifu_inst !== NOP || o_ifu_valid !== 1'b0) begin failures++;
      $display("FAIL handoff1 got=%0d/%h/%h/%0b exp=1/80000004/%h/0", o_ifu_fetch_cnt, o_ifu_req_addr, o_ifu_inst, o_ifu_valid, NOP); end
    fetch_one(32'h0010_0113);
    checks++; if (o_ifu_valid !== 1'b1 || o_ifu_pc !== 32'h8000_0004) begin failures++;
      $display("FAIL hold2 got=%0b/%h exp=1/80000004", o_ifu_valid, o_ifu_pc); end
    step();
    fetch_one(32'h0020_0193);
    checks++; if (o_ifu_valid !== 1'b1 || o_ifu_pc !== 32'h8000_0008 || o_ifu_inst !== 32'h0020_0193) begin failures++;
      $display("FAIL hold3 got=%0b/%h/%h exp=1/80000008/00200193", o_ifu_valid, o_ifu_pc, o_ifu_inst); end
    step();
    i_idu_ready = 1'b0;
    checks++; if (o_ifu_fetch_cnt !== 32'd3 || o_ifu_req_addr !== 32'h8000_000C) begin failures++;
      $display("FAIL handoff3 got=%0d/%h exp=3/8000000c", o_ifu_fetch_cnt, o_ifu_req_addr); end
  endtask

  task automatic test_hold_stall();
    int bad = 0;
    fetch_one(32'h00A0_0113);
    for (int i = 0; i < 5; i++) begin
      step();
      if (o_ifu_valid !== 1'b1 || o_ifu_pc !== 32'h8000_000C || o_ifu_inst !== 32'h00A0_0113 || o_ifu_fetch_cnt !== 32'd3) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL hold_stable got=%0d_bad_cycles exp=0", bad); end
    i_idu_ready = 1'b1;
    step();
    i_idu_ready = 1'b0;
    checks++; if (o_ifu_fetch_cnt !== 32'd4 || o_ifu_valid !== 1'b0 || o_ifu_req_addr !== 32'h8000_0010) begin failures++;
      $display("FAIL stall_release got=%0d/%0b/%h exp=4/0/80000010", o_ifu_fetch_cnt, o_ifu_valid, o_ifu_req_addr); end
  endtask

  task automatic test_mem_ignored();
    i_mem_rsp_valid = 1'b1; i_mem_rsp_data = 32'hBAD0_BAD0;
    step(); step();
    i_mem_rsp_valid = 1'b0;
    checks++; if (o_ifu_req_valid !== 1'b1 || o_ifu_valid !== 1'b0 || o_ifu_req_addr !== 32'h8000_0010) begin failures++;
      $display("FAIL stray_rsp got=%0b/%0b/%h exp=1/0/80000010", o_ifu_req_valid, o_ifu_valid, o_ifu_req_addr); end
  endtask

  task automatic test_redirect_wait();
    int seen = 0;
    i_mem_req_ready = 1'b1;
    step();
    i_mem_req_ready = 1'b0;
    i_exu_redirect = 1'b1; i_exu_redirect_pc = 32'h8000_0103;
    step();
    i_exu_redirect = 1'b0;
    if (o_ifu_valid !== 1'b0) seen++;
    checks++; if (o_ifu_req_valid !== 1'b0) begin failures++; $display("FAIL drop_no_req got=%0b exp=0", o_ifu_req_valid); end
    step();
    if (o_ifu_valid !== 1'b0) seen++;
    i_mem_rsp_valid = 1'b1; i_mem_rsp_data = 32'hDEAD_BEEF;
    step();
    i_mem_rsp_valid = 1'b0;
    if (o_ifu_valid !== 1'b0) seen++;
    step();
    if (o_ifu_valid !== 1'b0) seen++;
    checks++; if (seen != 0) begin failures++; $display("FAIL dropped_word_valid got=%0d exp=0", seen); end
    checks++; if (o_ifu_req_valid !== 1'b1 || o_ifu_req_addr !== 32'h8000_0100) begin failures++;
      $display("FAIL redirect_addr got=%0b/%h exp=1/80000100", o_ifu_req_valid, o_ifu_req_addr); end
    // redirect coincident with the response: word discarded, straight back to REQ
    i_mem_req_ready = 1'b1;
    step();
    i_mem_req_ready = 1'b0;
    i_exu_redirect = 1'b1; i_exu_redirect_pc = 32'h8000_0202;
    i_mem_rsp_valid = 1'b1; i_mem_rsp_data = 32'h1111_1111;
    step();
    i_exu_redirect = 1'b0; i_mem_rsp_valid = 1'b0;
    checks++; if (o_ifu_req_valid !== 1'b1 || o_ifu_valid !== 1'b0 || o_ifu_req_addr !== 32'h8000_0200) begin failures++;
      $display("FAIL redirect_rsp_same got=%0b/%0b/%h exp=1/0/80000200", o_ifu_req_valid, o_ifu_valid, o_ifu_req_addr); end
  endtask

  task automatic test_redirect_hold();
    fetch_one(32'h0000_0033);
    i_idu_ready = 1'b1; i_exu_redirect = 1'b1; i_exu_redirect_pc = 32'h8000_0040;
    step();
    i_idu_ready = 1'b0; i_exu_redirect = 1'b0;
    checks++; if (o_ifu_fetch_cnt !== 32'd4 || o_ifu_valid !== 1'b0 || o_ifu_req_addr !== 32'h8000_0040) begin failures++;
      $display("FAIL redirect_hold got=%0d/%0b/%h exp=4/0/80000040", o_ifu_fetch_cnt, o_ifu_valid, o_ifu_req_addr); end
  endtask

  task automatic test_pc_wrap();
    i_exu_redirect = 1'b1; i_exu_redirect_pc = 32'hFFFF_FFFF;
    step();
    i_exu_redirect = 1'b0;
    checks++; if (o_ifu_req_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL redirect_align got=%h exp=fffffffc", o_ifu_req_addr); end
    fetch_one(32'h0000_0073);
    i_idu_ready = 1'b1;
    step();
    i_idu_ready = 1'b0;
    checks++; if (o_ifu_req_addr !== 32'h0000_0000 || o_ifu_fetch_cnt !== 32'd5) begin failures++;
      $display("FAIL pc_wrap got=%h/%0d exp=00000000/5", o_ifu_req_addr, o_ifu_fetch_cnt); end
  endtask

  task automatic test_reset_mid();
    i_mem_req_ready = 1'b1;
    step();
    i_mem_req_ready = 1'b0;
    i_rst = 1'b0;
    #1;
    checks++; if (o_ifu_req_valid !== 1'b0 || o_ifu_valid !== 1'b0 || o_ifu_fetch_cnt !== 32'd0 ||
                  o_ifu_pc !== 32'h8000_0000 || o_ifu_inst !== NOP || o_ifu_req_addr !== 32'h8000_0000) begin failures++;
      $display("FAIL async_rst got=%0b/%0b/%0d/%h/%h/%h exp=0/0/0/80000000/%h/80000000",
               o_ifu_req_valid, o_ifu_valid, o_ifu_fetch_cnt, o_ifu_pc, o_ifu_inst, o_ifu_req_addr, NOP); end
    step();
    i_rst = 1'b1;
    i_mem_rsp_valid = 1'b1; i_mem_rsp_data = 32'hDEAD_BEEF;
    step(); step();
    i_mem_rsp_valid = 1'b0;
    checks++; if (o_ifu_req_valid !== 1'b1 || o_ifu_valid !== 1'b0 || o_ifu_req_addr !== 32'h8000_0000) begin failures++;
      $display("FAIL stale_rsp got=%0b/%0b/%h exp=1/0/80000000", o_ifu_req_valid, o_ifu_valid, o_ifu_req_addr); end
    fetch_one(32'h0050_0093);
    checks++; if (o_ifu_valid !== 1'b1 || o_ifu_pc !== 32'h8000_0000 || o_ifu_inst !== 32'h0050_0093) begin failures++;
      $display("FAIL restart got=%0b/%h/%h exp=1/80000000/00500093", o_ifu_valid, o_ifu_pc, o_ifu_inst); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_back_to_back();
    test_hold_stall();
    test_mem_ignored();
    test_redirect_wait();
    test_redirect_hold();
    test_pc_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
